pmp_match_unit: RTL
===================

Name: pmp_match_unit

Overview:
- One pattern-matching engine of the pattern-matching peripheral, downstream of the memory-mapped PMP front end. Four instances sit behind the front end; instance i receives the front end's per-module data, control and data_ready, and returns bit i of its data_accepted and pattern_accepted vectors.
- Stores a pattern of up to 8 bytes and scans streamed 64-bit beats byte-serially, one byte per cycle.
- Detects matches across beat boundaries and reports a sticky match flag plus a match count.

Parameters:
- MAX_LEN, 8, maximum pattern length in bytes; this is also the number of bytes per beat.
- CNT_W, 8, width of match_count; the count saturates.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- data  input  64  beat payload; byte k = data[8k+7:8k], byte 0 is processed first
- control  input  16  [15:14] op: 00 NOP, 01 LOAD, 10 STREAM, 11 CLEAR; [13:11] length-1 (1..8 bytes); [10] continue; [9:0] reserved, ignored
- data_ready  input  1  command-valid level from the front end; 0 for NOP
- data_accepted  output  1  four-phase acknowledge
- pattern_accepted  output  1  sticky match flag
- match_count  output  CNT_W  number of matches since the last LOAD/CLEAR, saturating

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; data_accepted=0, pattern_accepted=0, match_count=0. Pattern, length, history and history count are cleared, and pattern_valid=0.
- Reset asserted mid-operation aborts the command. After release, the engine waits in IDLE.
- States: IDLE, SCAN, ACK.
- IDLE: on a clk edge with data_ready=1, latch data and control, then act on op:
  - LOAD: pattern<=data, plen<=control[13:11]+1, pattern_valid=1. Clear history, history count, pattern_accepted and match_count. Set data_accepted=1 at this same edge. Go to ACK.
  - CLEAR: clear history, history count, pattern_accepted and match_count. Keep the pattern. Set data_accepted=1 at this edge. Go to ACK.
  - STREAM: nbytes<=control[13:11]+1. If control[10]=0, clear history and history count at this edge. Byte index<=0. Go to SCAN.
  - NOP with data_ready=1 is never sent by the front end. If it occurs, ack it like CLEAR but with no side effects.
- SCAN: each edge processes one byte b = data byte[idx].
  - Shift b into an 8-byte history (newest at position 0). Update histcnt = min(histcnt+1, 8).
  - Match condition, evaluated combinationally on the post-shift history: pattern_valid && histcnt>=plen && history[plen-1-j]==pattern byte j for all j<plen.
  - On a match: pattern_accepted<=1 and match_count<=match_count+1, saturating at 2^CNT_W-1.
  - Overlapping matches each count.
  - After the byte at idx=nbytes-1 is processed, set data_accepted<=1 and go to ACK at that same edge. An n-byte STREAM therefore acks at the n-th edge after capture.
- ACK: data_accepted stays 1 while data_ready=1. At the first edge sampling data_ready=0, data_accepted<=0 and the state returns to IDLE. A new command is accepted no earlier than the following edge.
- If data_ready drops during SCAN, the scan still completes and acks. The ACK then clears at the next edge.
- Bytes beyond nbytes are ignored. History persists across beats only when the next STREAM has continue=1.
- pattern_accepted is cleared only by reset, LOAD or CLEAR.
- A STREAM with pattern_valid=0 scans and acks, but never matches.

Test Plan:
- Basic match: LOAD data=64'h434241, ctrl=0x5000 (pattern "ABC", len 3) -> data_accepted=1 one edge after capture; drop data_ready -> data_accepted=0. Then STREAM data=64'h43424100, ctrl=0xB800 -> pattern_accepted=1 at the 4th scan edge, match_count=1, data_accepted=1 at the 8th edge.
- Cross-beat match: beat1 data=64'h4241000000000000, ctrl=0xB800 -> no match. Beat2 data=64'h43, ctrl=0xBC00 -> match on the first scan edge, count=1. Repeat with beat2 ctrl=0xB800 -> no match, count unchanged.
- Overlap and short beat: LOAD data=64'h4141, ctrl=0x4800 (pattern "AA"). STREAM data=64'h414141, ctrl=0x9000 (3 bytes) -> match_count=2, ack at the 3rd edge.
- CLEAR: ctrl=0xC000 after a match -> pattern_accepted=0, match_count=0. A following STREAM of "ABC" with the pattern retained still matches.
- Reset: assert reset=0 at scan byte 2 -> all outputs 0 immediately, asynchronously. After release, STREAM does not match because pattern_valid=0, and it still acks.
- Saturation with CNT_W=2: five matches -> match_count=3.

Source files
------------

// File: rtl/pmp_match_unit.sv
// One pattern-matching engine: holds a pattern of up to MAX_LEN bytes and scans
// streamed beats one byte per cycle, counting (overlapping) matches across beats.
module pmp_match_unit #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [8*MAX_LEN-1:0]   data,
    input  logic [15:0]            control,
    input  logic                   data_ready,
    output logic                   data_accepted,
    output logic                   pattern_accepted,
    output logic [CNT_W-1:0]       match_count
);
    localparam int IW = $clog2(MAX_LEN);
    localparam int LW = $clog2(MAX_LEN + 1);

    localparam logic [1:0] OP_LOAD   = 2'b01;
    localparam logic [1:0] OP_STREAM = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

    typedef enum logic [1:0] {IDLE, SCAN, ACK} state_t;
    state_t state, state_next;

    logic [7:0]    pattern      [MAX_LEN];
    logic [7:0]    history      [MAX_LEN];
    logic [7:0]    beat         [MAX_LEN];
    logic [7:0]    history_next [MAX_LEN];
    logic [LW-1:0] plen, histcnt, histcnt_next, nbytes, cmd_len;
    logic [IW-1:0] idx;
    logic          pattern_valid, match, last_byte;
    logic [1:0]    op;
    logic          unused_ctrl;

    assign op          = control[15:14];
    assign cmd_len     = LW'(control[13:11]) + LW'(1);
    assign unused_ctrl = ^control[9:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (data_ready) state_next = (op == OP_STREAM) ? SCAN : ACK;
            SCAN:    if (last_byte) state_next = ACK;
            ACK:     if (!data_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The match is judged on the history as it will look after the current byte
    // is shifted in, so a match is flagged on the same edge that consumes its last byte.
    always_comb begin
        history_next[0] = beat[idx];
        for (int p = 1; p < MAX_LEN; p++) history_next[p] = history[p-1];
        histcnt_next = (histcnt == LW'(MAX_LEN)) ? histcnt : histcnt + LW'(1);
        match = pattern_valid && (histcnt_next >= plen);
        for (int j = 0; j < MAX_LEN; j++) begin
            if (LW'(j) < plen &&
                history_next[IW'(plen - LW'(1) - LW'(j))] != pattern[j])
                match = 1'b0;
        end
        last_byte = (LW'(idx) == nbytes - LW'(1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < MAX_LEN; k++) begin
                pattern[k] <= '0;
                history[k] <= '0;
                beat[k]    <= '0;
            end
            plen             <= '0;
            histcnt          <= '0;
            nbytes           <= '0;
            idx              <= '0;
            pattern_valid    <= 1'b0;
            data_accepted    <= 1'b0;
            pattern_accepted <= 1'b0;
            match_count      <= '0;
        end else begin
            case (state)
                IDLE: if (data_ready) begin
                    for (int k = 0; k < MAX_LEN; k++) beat[k] <= data[8*k +: 8];
                    case (op)
                        OP_LOAD: begin
                            for (int k = 0; k < MAX_LEN; k++) begin
                                pattern[k] <= data[8*k +: 8];
                                history[k] <= '0;
                            end
                            plen             <= cmd_len;
                            pattern_valid    <= 1'b1;
                            histcnt          <= '0;
                            pattern_accepted <= 1'b0;
                            match_count      <= '0;
                            data_accepted    <= 1'b1;
                        end
                        OP_CLEAR: begin
                            for (int k = 0; k < MAX_LEN; k++) history[k] <= '0;
                            histcnt          <= '0;
                            pattern_accepted <= 1'b0;
                            match_count      <= '0;
                            data_accepted    <= 1'b1;
                        end
                        OP_STREAM: begin
                            nbytes <= cmd_len;
                            idx    <= '0;
                            if (!control[10]) begin
                                for (int k = 0; k < MAX_LEN; k++) history[k] <= '0;
                                histcnt <= '0;
                            end
                        end
                        // A stray NOP is simply acknowledged.
                        default: data_accepted <= 1'b1;
                    endcase
                end
                SCAN: begin
                    for (int k = 0; k < MAX_LEN; k++) history[k] <= history_next[k];
                    histcnt <= histcnt_next;
                    idx     <= idx + IW'(1);
                    if (match) begin
                        pattern_accepted <= 1'b1;
                        if (match_count != '1) match_count <= match_count + CNT_W'(1);
                    end
                    if (last_byte) data_accepted <= 1'b1;
                end
                ACK: if (!data_ready) data_accepted <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule
